// File: rtl/matrix_axil_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite register arbiter.
package matrix_axil_pkg;

    localparam int unsigned N_REQ = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_AW_W,
        ST_WR_B,
        ST_RD_AR,
        ST_RD_R,
        ST_RESP
    } axil_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [3:0] REG_OFS_0 = 4'h0;
    localparam logic [3:0] REG_OFS_1 = 4'h4;
    localparam logic [3:0] REG_OFS_2 = 4'h8;
    localparam logic [3:0] REG_OFS_3 = 4'hC;

endpackage

// File: rtl/matrix_rr_arb2.sv
// Two-way round-robin grant; on a tie the requester not granted last wins.
module matrix_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant_c,
    output logic       grant_idx_c
);

    logic last;

    always_comb begin
        grant_idx_c = 1'b0;
        grant_c     = 2'b00;
        if (req == 2'b11) begin
            grant_idx_c = ~last;
        end else begin
            grant_idx_c = req[1];
        end
        if (|req) begin
            grant_c = grant_idx_c ? 2'b10 : 2'b01;
        end
    end

    // Reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (update) begin
            last <= grant_idx_c;
        end
    end

endmodule

// File: rtl/matrix_axil_arbiter.sv
// Arbitrates two register requesters onto one AXI4-Lite master port,
// one transfer in flight at a time.
module matrix_axil_arbiter
    import matrix_axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ-1:0]              req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [N_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic [ADDR_WIDTH-1:0]         M_AXI_AWADDR,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]         M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]       M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]         M_AXI_ARADDR,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]         M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    axil_state_t state;
    logic        gnt_idx;
    logic        launch;
    logic        aw_done;
    logic        w_done;

    logic [N_REQ-1:0]      grant_c;
    logic                  grant_idx_c;
    logic                  arb_update_c;
    logic                  sel_we_c;
    logic [ADDR_WIDTH-1:0] sel_addr_c;
    logic [ADDR_WIDTH-1:0] aligned_addr_c;
    logic [DATA_WIDTH-1:0] sel_wdata_c;
    logic                  aw_hs_c;
    logic                  w_hs_c;
    logic                  aw_done_c;
    logic                  w_done_c;
    logic                  unused_resp_c;

    matrix_rr_arb2 u_arb (
        .clk         (ACLK),
        .rst         (ARESET),
        .req         (req_valid),
        .update      (arb_update_c),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c)
    );

    assign arb_update_c   = (state == ST_IDLE) && (|req_valid);
    assign sel_we_c       = req_we[grant_idx_c];
    assign sel_addr_c     = grant_idx_c ? req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                                        : req_addr[0 +: ADDR_WIDTH];
    assign sel_wdata_c    = grant_idx_c ? req_wdata[DATA_WIDTH +: DATA_WIDTH]
                                        : req_wdata[0 +: DATA_WIDTH];
    assign aligned_addr_c = sel_addr_c & ~ADDR_WIDTH'(3);

    assign aw_hs_c   = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs_c    = M_AXI_WVALID & M_AXI_WREADY;
    assign aw_done_c = aw_done | aw_hs_c;
    assign w_done_c  = w_done | w_hs_c;

    assign M_AXI_WSTRB   = {STRB_WIDTH{1'b1}};
    // Only RESP[1] (SLVERR/DECERR) is reported to requesters.
    assign unused_resp_c = M_AXI_BRESP[0] ^ M_AXI_RRESP[0];

    // Transfer FSM; launch delays VALID one cycle past the grant cycle.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state         <= ST_IDLE;
            gnt_idx       <= 1'b0;
            launch        <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            req_ready     <= '0;
            rsp_valid     <= '0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        req_ready <= grant_c;
                        gnt_idx   <= grant_idx_c;
                        launch    <= 1'b1;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        if (sel_we_c) begin
                            M_AXI_AWADDR <= aligned_addr_c;
                            M_AXI_WDATA  <= sel_wdata_c;
                            state        <= ST_WR_AW_W;
                        end else begin
                            M_AXI_ARADDR <= aligned_addr_c;
                            state        <= ST_RD_AR;
                        end
                    end
                end
                ST_WR_AW_W: begin
                    if (launch) begin
                        launch        <= 1'b0;
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                    end else begin
                        if (aw_hs_c) M_AXI_AWVALID <= 1'b0;
                        if (w_hs_c)  M_AXI_WVALID  <= 1'b0;
                        aw_done <= aw_done_c;
                        w_done  <= w_done_c;
                        if (aw_done_c && w_done_c) begin
                            M_AXI_BREADY <= 1'b1;
                            state        <= ST_WR_B;
                        end
                    end
                end
                ST_WR_B: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        rsp_rdata    <= '0;
                        rsp_err      <= M_AXI_BRESP[1];
                        state        <= ST_RESP;
                    end
                end
                ST_RD_AR: begin
                    if (launch) begin
                        launch        <= 1'b0;
                        M_AXI_ARVALID <= 1'b1;
                    end else if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= ST_RD_R;
                    end
                end
                ST_RD_R: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        rsp_rdata    <= M_AXI_RDATA;
                        rsp_err      <= M_AXI_RRESP[1];
                        state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    rsp_valid <= gnt_idx ? 2'b10 : 2'b01;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_axil_arbiter.sv
// Directed bench: two requesters against a small AXI4-Lite register slave model.
module tb_matrix_axil_arbiter;
    import matrix_axil_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [3:0]  M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WSTRB;
    logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;

    int total = 0;
    int bad = 0;

    matrix_axil_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Register slave with programmable AW/W ready delays, B hold-off and read error injection.
    int          aw_delay = 0, w_delay = 0, aw_cnt, w_cnt;
    bit          b_hold = 1'b0, err_en = 1'b0;
    int          b_count = 0;
    logic        aw_got, w_got;
    logic [3:0]  aw_addr_q, last_awaddr;
    logic [31:0] w_data_q;
    logic [31:0] mem [4];
    logic        aw_have, w_have;
    logic [3:0]  addr_use;
    logic [31:0] data_use;

    assign M_AXI_AWREADY = M_AXI_AWVALID && !aw_got && (aw_cnt >= aw_delay);
    assign M_AXI_WREADY  = M_AXI_WVALID && !w_got && (w_cnt >= w_delay);
    assign M_AXI_ARREADY = M_AXI_ARVALID;
    assign aw_have  = aw_got || (M_AXI_AWVALID && M_AXI_AWREADY);
    assign w_have   = w_got || (M_AXI_WVALID && M_AXI_WREADY);
    assign addr_use = aw_got ? aw_addr_q : M_AXI_AWADDR;
    assign data_use = w_got ? w_data_q : M_AXI_WDATA;

    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
            M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
            M_AXI_RVALID <= 1'b0; M_AXI_RRESP <= 2'b00; M_AXI_RDATA <= 32'h0;
        end else begin
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_got <= 1'b1; aw_addr_q <= M_AXI_AWADDR; last_awaddr <= M_AXI_AWADDR; aw_cnt <= 0;
            end else if (M_AXI_AWVALID) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                w_got <= 1'b1; w_data_q <= M_AXI_WDATA; w_cnt <= 0;
            end else if (M_AXI_WVALID) begin
                w_cnt <= w_cnt + 1;
            end
            if (aw_have && w_have && !M_AXI_BVALID && !b_hold) begin
                mem[addr_use[3:2]] <= data_use;
                M_AXI_BVALID <= 1'b1; M_AXI_BRESP <= AXI_RESP_OKAY;
                aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) begin
                M_AXI_BVALID <= 1'b0; b_count <= b_count + 1;
            end
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                M_AXI_RVALID <= 1'b1;
                M_AXI_RDATA  <= mem[M_AXI_ARADDR[3:2]];
                M_AXI_RRESP  <= (err_en && M_AXI_ARADDR == REG_OFS_2) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end
            if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
        end
    end

    // A stalled VALID must stay up with its address/data unchanged.
    bit          aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
    logic [3:0]  aw_addr_p, ar_addr_p;
    logic [31:0] w_data_p;
    always @(negedge ACLK) begin
        if (!ARESET && aw_pend) check("aw_hold", 64'({M_AXI_AWVALID, M_AXI_AWADDR}), 64'({1'b1, aw_addr_p}));
        if (!ARESET && w_pend)  check("w_hold", 64'({M_AXI_WVALID, M_AXI_WDATA}), 64'({1'b1, w_data_p}));
        if (!ARESET && ar_pend) check("ar_hold", 64'({M_AXI_ARVALID, M_AXI_ARADDR}), 64'({1'b1, ar_addr_p}));
        aw_pend   <= M_AXI_AWVALID && !M_AXI_AWREADY;
        w_pend    <= M_AXI_WVALID && !M_AXI_WREADY;
        ar_pend   <= M_AXI_ARVALID && !M_AXI_ARREADY;
        aw_addr_p <= M_AXI_AWADDR;
        w_data_p  <= M_AXI_WDATA;
        ar_addr_p <= M_AXI_ARADDR;
    end

    // One command from requester r; exp_lat of 0 skips the latency check.
    task automatic do_cmd(input int r, input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                          input string tag);
        bit seen;
        int lat;
        req_we[r] = we;
        req_addr[r*4 +: 4] = addr;
        req_wdata[r*32 +: 32] = wdata;
        req_valid[r] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge ACLK);
            if (req_ready[r]) seen = 1'b1;
        end
        check({tag, "_grant"}, 64'(seen), 64'(1));
        req_valid[r] = 1'b0;
        if (!seen) return;
        lat = 1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge ACLK);
            lat++;
            if (|rsp_valid) seen = 1'b1;
        end
        check({tag, "_owner"}, 64'(rsp_valid), 64'(r == 1 ? 2'b10 : 2'b01));
        if (!seen) return;
        if (exp_lat != 0) check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
        check({tag, "_err"}, 64'(rsp_err), 64'(exp_err));
        @(negedge ACLK);
        check({tag, "_pulse"}, 64'(rsp_valid), 64'(0));
    endtask

    initial begin
        bit seen;
        bit any_rsp;
        int b_before;
        req_valid = 2'b00; req_we = 2'b00; req_addr = 8'h0; req_wdata = 64'h0;
        repeat (3) @(negedge ACLK);
        check("rst_outs", 64'({req_ready, rsp_valid, rsp_rdata, rsp_err, M_AXI_AWVALID, M_AXI_WVALID,
                               M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWADDR, M_AXI_ARADDR}), 64'(0));
        check("wstrb", 64'(M_AXI_WSTRB), 64'(4'hF));
        ARESET = 1'b0;
        @(negedge ACLK);

        // Write 1..4 to the four registers, then read them back.
        for (int i = 0; i < 4; i++) do_cmd(0, 1'b1, 4'(i * 4), 32'(i + 1), 32'h0, 1'b0, 5, "wr_reg");
        for (int i = 0; i < 4; i++) do_cmd(0, 1'b0, 4'(i * 4), 32'h0, 32'(i + 1), 1'b0, 5, "rd_reg");

        // Reset in IDLE restores last-grant so requester 0 wins the tie.
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);

        // Continuous contention: r0 writes 0xA5 to 0x0, r1 reads 0x4.
        req_we = 2'b01;
        req_addr = {REG_OFS_1, REG_OFS_0};
        req_wdata = {32'h0, 32'h0000_00A5};
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            seen = 1'b0;
            for (int i = 0; i < 30 && !seen; i++) begin
                @(negedge ACLK);
                if (|req_ready) seen = 1'b1;
            end
            check("tie_grant", 64'(req_ready), 64'((k % 2 == 1) ? 2'b10 : 2'b01));
            if (k == 3) req_valid = 2'b00;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge ACLK);
                if (|rsp_valid) seen = 1'b1;
            end
            check("tie_owner", 64'(rsp_valid), 64'((k % 2 == 1) ? 2'b10 : 2'b01));
            check("tie_rdata", 64'(rsp_rdata), 64'((k % 2 == 1) ? 32'h2 : 32'h0));
        end
        @(negedge ACLK);

        // Slow AWREADY with immediate WREADY, unaligned address.
        aw_delay = 3; w_delay = 0;
        b_before = b_count;
        do_cmd(0, 1'b1, 4'hA, 32'h5A, 32'h0, 1'b0, 0, "wr_awslow");
        check("wr_awslow_b", 64'(b_count - b_before), 64'(1));
        check("awaddr_align", 64'(last_awaddr), 64'(REG_OFS_2));
        // Slow WREADY with immediate AWREADY.
        aw_delay = 0; w_delay = 3;
        b_before = b_count;
        do_cmd(1, 1'b1, REG_OFS_3, 32'h77, 32'h0, 1'b0, 0, "wr_wslow");
        check("wr_wslow_b", 64'(b_count - b_before), 64'(1));
        w_delay = 0;
        do_cmd(1, 1'b0, REG_OFS_3, 32'h0, 32'h77, 1'b0, 5, "rd_wslow");
        do_cmd(0, 1'b0, REG_OFS_2, 32'h0, 32'h5A, 1'b0, 5, "rd_awslow");

        // Slave error on 0x8 surfaces as rsp_err.
        err_en = 1'b1;
        do_cmd(0, 1'b0, REG_OFS_2, 32'h0, 32'h5A, 1'b1, 5, "rd_slverr");
        err_en = 1'b0;

        // Reset while waiting in WR_B abandons the write.
        b_hold = 1'b1;
        req_we[0] = 1'b1; req_addr[3:0] = REG_OFS_1; req_wdata[31:0] = 32'h99; req_valid[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge ACLK);
            if (req_ready[0]) seen = 1'b1;
        end
        req_valid[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge ACLK);
            if (M_AXI_BREADY) seen = 1'b1;
        end
        check("wrb_reached", 64'(seen), 64'(1));
        ARESET = 1'b1;
        #1;
        check("midrst_outs", 64'({req_ready, rsp_valid, rsp_rdata, rsp_err, M_AXI_AWVALID, M_AXI_WVALID,
                                  M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWADDR, M_AXI_ARADDR}), 64'(0));
        any_rsp = 1'b0;
        repeat (2) begin
            @(negedge ACLK);
            any_rsp = any_rsp | (|rsp_valid);
        end
        ARESET = 1'b0;
        b_hold = 1'b0;
        repeat (6) begin
            @(negedge ACLK);
            any_rsp = any_rsp | (|rsp_valid);
        end
        check("midrst_no_rsp", 64'(any_rsp), 64'(0));
        do_cmd(0, 1'b0, REG_OFS_0, 32'h0, 32'hA5, 1'b0, 5, "rd_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
